aes128_round_sequencer: RTL
===========================

# aes128_round_sequencer

Iterative control block for the AES-128 encryption datapath. It accepts one plaintext/cipher-key pair, performs the initial AddRoundKey itself, then issues rounds 1..10 one at a time to the shared round datapath (rounds 1–9 full, round 10 flagged final: no MixColumns). Round keys are fetched from the key-expansion unit over a request/valid port. It returns the ciphertext on a valid/ready output.

## Interface
- NR, 10, number of rounds issued; the last one is flagged final.
- DP_LAT, 2, round datapath latency in cycles from issue to result valid; legal range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  plaintext/key pair offered.
- in_ready  out  1  high only in IDLE.
- in_block  in  128  plaintext; [127:120] is byte 0 (FIPS-197 order, column-major).
- in_key  in  128  cipher key, same byte order.
- rk_req  out  1  round-key request; held until rk_valid.
- rk_round  out  4  round index requested (1..NR).
- rk_cipher_key  out  128  latched cipher key for the key-expansion unit.
- rk_valid  in  1  rk_key valid for rk_round.
- rk_key  in  128  round key.
- dp_valid  out  1  one-cycle issue pulse to the round datapath.
- dp_final  out  1  high with dp_valid when round == NR.
- dp_round  out  4  current round index.
- dp_state  out  128  state register contents.
- dp_key  out  128  latched round key.
- dp_result  in  128  round datapath output.
- out_valid  out  1  ciphertext available; held until out_ready.
- out_ready  in  1  consumer accepts.
- out_block  out  128  ciphertext, equal to the state register.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, KEY, ISSUE, WAIT, DONE.
- IDLE: on in_valid high, state_reg <= in_block ^ in_key, key_reg <= in_key, round <= 1, then go to KEY.
- KEY: rk_req=1 and rk_round=round. When rk_valid is high, rkey_reg <= rk_key and go to ISSUE. rk_valid may arrive in the same cycle as the request. rk_valid in any other state is ignored.
- ISSUE: dp_valid=1 for exactly one cycle, with dp_state=state_reg, dp_key=rkey_reg, and dp_final=(round==NR). Load wait counter with DP_LAT and go to WAIT.
- WAIT: decrement the counter once per cycle. In the cycle the counter equals 1, capture state_reg <= dp_result. Then:
  - if round == NR, go to DONE;
  - otherwise round <= round+1 and go to KEY.
- DONE: out_valid=1 and out_block=state_reg, stable. When out_ready is high, go to IDLE.
- Round counter and wait counter are 4-bit; round never exceeds NR and never wraps.
- in_valid while not in IDLE is ignored; nothing is latched.
- dp_result is sampled only in the capture cycle; its value in other cycles is don't-care.

## Timing
- Reset, asynchronous:
  - FSM goes to IDLE; state_reg, key_reg, rkey_reg and round clear to 0.
  - dp_valid, rk_req, out_valid and busy are 0, and all data outputs are 0.
  - in_ready=1 as soon as rst_n is low.
- Reset mid-operation aborts the block. Any in-flight datapath result is discarded. The first accept after release starts from round 1.
- Accept at edge E0. With rk_valid returned in the request cycle, each round takes DP_LAT+2 cycles (KEY 1, ISSUE 1, WAIT DP_LAT).
- out_valid rises at edge E0 + NR·(DP_LAT+2). With the defaults that is 40 cycles after accept.
- Each cycle of rk_valid delay adds one cycle to that round.
- The dp_valid issue for round r+1 follows the capture of round r by at least 2 cycles.
- in_ready drops in the cycle after accept. It returns the cycle after the out_valid && out_ready handshake.
- There is no back-to-back accept in the DONE handshake cycle.

## Test plan
- FIPS-197 C.1 vector:
  - Stimulus: in_block=00112233445566778899aabbccddeeff, in_key=000102030405060708090a0b0c0d0e0f; behavioural datapath with DP_LAT=2; key unit answers immediately.
  - Required: first dp_state=00102030405060708090a0b0c0d0e0f0; out_block=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 40 cycles after accept.
- Round sequencing: exactly 10 dp_valid pulses with dp_round 1..10; dp_final high only on round 10.
- Key stall: rk_valid delayed 3 cycles for round 5 only -> same ciphertext; completion at 43 cycles; no dp_valid while rk_req is high.
- Output backpressure: out_ready low for 7 cycles -> out_valid and out_block stable; in_ready=0; in_valid pulses during busy are ignored. Accept occurs the cycle after the handshake.
- Reset during round 6 WAIT -> all outputs 0 immediately; in_ready=1. The next vector completes correctly in 40 cycles.
- DP_LAT=1 and DP_LAT=5 builds -> correct ciphertext; latency 30 and 70 cycles respectively.

Source files
------------

// File: rtl/aes128_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : aes128_round_sequencer
//  Purpose  : Iterative AES-128 round control: initial AddRoundKey, then
//             rounds 1..NR issued one at a time to a shared round datapath.
//  Revision : 1.0  initial release
// ============================================================================
module aes128_round_sequencer #(
  parameter int NR     = 10,
  parameter int DP_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  // plaintext / key intake
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  // key-expansion unit
  output logic         rk_req,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_cipher_key,
  input  logic         rk_valid,
  input  logic [127:0] rk_key,
  // round datapath
  output logic         dp_valid,
  output logic         dp_final,
  output logic [3:0]   dp_round,
  output logic [127:0] dp_state,
  output logic [127:0] dp_key,
  input  logic [127:0] dp_result,
  // ciphertext output
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  localparam logic [3:0] C_NR     = 4'(NR);
  localparam logic [3:0] C_DP_LAT = 4'(DP_LAT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEY   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t       r_fsm;
  state_t       w_fsm_nxt;
  logic [127:0] r_blk;
  logic [127:0] r_key;
  logic [127:0] r_rkey;
  logic [3:0]   r_round;
  logic [3:0]   r_wcnt;

  logic         w_accept;
  logic         w_rk_take;
  logic         w_capture;
  logic         w_last;

  assign w_last = (r_round == C_NR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_accept  = 1'b0;
    w_rk_take = 1'b0;
    w_capture = 1'b0;
    in_ready  = 1'b0;
    rk_req    = 1'b0;
    dp_valid  = 1'b0;
    dp_final  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_accept  = 1'b1;
          w_fsm_nxt = S_KEY;
        end
      end
      S_KEY: begin
        rk_req = 1'b1;
        if (rk_valid) begin
          w_rk_take = 1'b1;
          w_fsm_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dp_valid  = 1'b1;
        dp_final  = w_last;
        w_fsm_nxt = S_WAIT;
      end
      S_WAIT: begin
        // <=1 rather than ==1 so a zero count can never strand the FSM here
        if (r_wcnt <= 4'd1) begin
          w_capture = 1'b1;
          w_fsm_nxt = w_last ? S_DONE : S_KEY;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_fsm_nxt = S_IDLE;
        end
      end
      default: begin
        w_fsm_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk   <= '0;
      r_key   <= '0;
      r_rkey  <= '0;
      r_round <= '0;
      r_wcnt  <= '0;
    end else begin
      if (w_accept) begin
        r_blk   <= in_block ^ in_key;
        r_key   <= in_key;
        r_round <= 4'd1;
      end else if (w_capture) begin
        r_blk <= dp_result;
        if (!w_last) begin
          r_round <= r_round + 4'd1;
        end
      end
      if (w_rk_take) begin
        r_rkey <= rk_key;
      end
      if (r_fsm == S_ISSUE) begin
        r_wcnt <= C_DP_LAT;
      end else if ((r_fsm == S_WAIT) && (r_wcnt != 4'd0)) begin
        r_wcnt <= r_wcnt - 4'd1;
      end
    end
  end

  assign rk_round      = r_round;
  assign rk_cipher_key = r_key;
  assign dp_round      = r_round;
  assign dp_state      = r_blk;
  assign dp_key        = r_rkey;
  assign out_block     = r_blk;

endmodule
`default_nettype wire
